// File: rtl/i2c_cmd_sequencer_if.sv
// Host command/response port plus the i2c_master control bus of the command sequencer.
// The slave modport is the sequencer; the master modport is the host / master-side model.
interface i2c_cmd_sequencer_if #(
  parameter int CMD_DEPTH = 8
);
  localparam int LEVEL_W = $clog2(CMD_DEPTH) + 1;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_rw;
  logic [6:0]         cmd_addr;
  logic [7:0]         cmd_data;
  logic [1:0]         speed_cfg;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [7:0]         rsp_data;
  logic               rsp_ack_err;
  logic               rsp_timeout;
  logic               halted;
  logic               clr;
  logic [LEVEL_W-1:0] cmd_level;
  logic               m_write;
  logic               m_read;
  logic [6:0]         m_addr;
  logic [7:0]         m_data_wr;
  logic [1:0]         m_speed_mode;
  logic [7:0]         m_data_rd;
  logic               m_done;
  logic               m_ack_error;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data, speed_cfg, rsp_ready, clr,
           m_data_rd, m_done, m_ack_error,
    output cmd_ready, rsp_valid, rsp_data, rsp_ack_err, rsp_timeout, halted, cmd_level,
           m_write, m_read, m_addr, m_data_wr, m_speed_mode
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data, speed_cfg, rsp_ready, clr,
           m_data_rd, m_done, m_ack_error,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ack_err, rsp_timeout, halted, cmd_level,
           m_write, m_read, m_addr, m_data_wr, m_speed_mode
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C commands and issues them one at a time to i2c_master, returning
// read data and ACK/timeout status over a ready/valid response port.
module i2c_cmd_sequencer #(
  parameter int CMD_DEPTH   = 8,
  parameter int TIMEOUT     = 65535,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input logic                clk,
  input logic                rst,
  i2c_cmd_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HALT} state_t;
  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  state_t           state, state_nx;
  cmd_t             mem [CMD_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] cnt;
  logic             full, empty, push, pop, flush, timed_out, err_stop;
  logic             rw_q, ack_err_q, timeout_q;
  logic [6:0]       addr_q;
  logic [7:0]       data_wr_q, rsp_data_q;
  logic [1:0]       speed_q;

  assign full      = (level == LVL_W'(CMD_DEPTH));
  assign empty     = (level == '0);
  assign push      = bus.cmd_valid && bus.cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign flush     = (state == HALT);
  assign head      = mem[rd_ptr];
  // Terminal count: the increment in this cycle would bring the counter to TIMEOUT-1.
  assign timed_out = (state == WAIT) && !bus.m_done && (cnt == CNT_W'(TIMEOUT - 2));
  assign err_stop  = timeout_q || (ack_err_q && STOP_ON_ERR);

  // NOTE: storage arrays carry no reset; level/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_t'{bus.cmd_rw, bus.cmd_addr, bus.cmd_data};
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: next state defaults to the current one first, so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!empty) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (bus.m_done || timed_out) state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = err_stop ? HALT : IDLE;
      HALT:    if (bus.clr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_wr_q  <= '0;
      speed_q    <= '0;
      cnt        <= '0;
      rsp_data_q <= '0;
      ack_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (pop) begin
        rw_q      <= head.rw;
        addr_q    <= head.addr;
        data_wr_q <= head.data;
        speed_q   <= bus.speed_cfg;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
      // m_done takes priority over a coincident terminal count.
      if (state == WAIT && bus.m_done) begin
        rsp_data_q <= rw_q ? bus.m_data_rd : 8'h00;
        ack_err_q  <= bus.m_ack_error;
        timeout_q  <= 1'b0;
      end else if (timed_out) begin
        rsp_data_q <= 8'h00;
        ack_err_q  <= 1'b0;
        timeout_q  <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready    = !full && (state != HALT);
  assign bus.cmd_level    = level;
  assign bus.halted       = (state == HALT);
  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_ack_err  = ack_err_q;
  assign bus.rsp_timeout  = timeout_q;
  assign bus.m_write      = (state == ISSUE) && !rw_q;
  assign bus.m_read       = (state == ISSUE) && rw_q;
  assign bus.m_addr       = addr_q;
  assign bus.m_data_wr    = data_wr_q;
  assign bus.m_speed_mode = speed_q;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Randomized bench for i2c_cmd_sequencer: a transaction-level model (command queue plus
// timestamped strobe/response expectations) predicts every output each cycle.
module tb_i2c_cmd_sequencer;
  localparam int DEPTH = 8;
  localparam int TMO   = 24;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_cmd_sequencer_if #(.CMD_DEPTH(DEPTH)) bus ();

  i2c_cmd_sequencer #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO), .STOP_ON_ERR(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: commands waiting in the FIFO, plus the one open transaction.
  cmd_t       q[$];
  bit         txn_open = 1'b0;
  bit         halt_m   = 1'b0;
  cmd_t       cur;
  logic [1:0] cur_speed;
  int         strobe_cyc = 0, done_cyc = -1, rsp_cyc = 0;
  logic [7:0] exp_rd, drv_rd;
  bit         exp_err, exp_to, drv_err;

  // Stimulus knobs.
  cmd_t push_q[$];
  int   push_pct = 0, rdy_pct = 100, clr_pct = 0, fixed_delay = 0, fixed_rd = -1;
  bit   force_err = 0, force_to = 0, force_clr = 0, force_done = 0, rst_req = 0;

  // Observations taken from the DUT for latency checks.
  int n_strobe = 0, last_strobe = 0, rsp_rise = 0, last_push = 0;
  bit rsp_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, act, exp);
    end
  endtask

  // Decide how the modelled i2c_master answers the command just popped.
  task automatic plan_txn();
    int k, r;
    if (force_to)             k = 0;
    else if (fixed_delay > 0) k = fixed_delay;
    else begin
      r = $urandom_range(0, 15);
      k = (r == 0) ? 0 : (r == 1) ? TMO - 1 : $urandom_range(1, TMO - 1);
    end
    drv_rd  = (fixed_rd >= 0) ? 8'(fixed_rd) : 8'($urandom);
    drv_err = force_err || (fixed_delay == 0 && $urandom_range(0, 9) == 0);
    if (k > 0) begin
      done_cyc = strobe_cyc + k;
      rsp_cyc  = done_cyc + 1;
      exp_rd   = cur.rw ? drv_rd : 8'h00;
      exp_err  = drv_err;
      exp_to   = 1'b0;
    end else begin
      done_cyc = -1;
      rsp_cyc  = strobe_cyc + TMO;
      exp_rd   = 8'h00;
      exp_err  = 1'b0;
      exp_to   = 1'b1;
    end
    force_to  = 1'b0;
    force_err = 1'b0;
  endtask

  task automatic step();
    cmd_t c;
    bit   exp_ready, pop_now, in_wait, strobe_now, rsp_now;
    @(negedge clk);
    cyc++;
    // Compare this cycle's outputs with the model.
    exp_ready  = !halt_m && (q.size() < DEPTH);
    strobe_now = txn_open && (cyc == strobe_cyc);
    rsp_now    = txn_open && (cyc >= rsp_cyc);
    check("cmd_ready", bus.cmd_ready, exp_ready);
    check("cmd_level", bus.cmd_level, q.size());
    check("halted", bus.halted, halt_m);
    check("m_write", bus.m_write, strobe_now && !cur.rw);
    check("m_read", bus.m_read, strobe_now && cur.rw);
    if (strobe_now) begin
      check("m_addr", bus.m_addr, cur.addr);
      check("m_data_wr", bus.m_data_wr, cur.data);
      check("m_speed_mode", bus.m_speed_mode, cur_speed);
    end
    check("rsp_valid", bus.rsp_valid, rsp_now);
    if (rsp_now) begin
      check("rsp_data", bus.rsp_data, exp_rd);
      check("rsp_ack_err", bus.rsp_ack_err, exp_err);
      check("rsp_timeout", bus.rsp_timeout, exp_to);
    end
    if (bus.m_write || bus.m_read) begin
      n_strobe++;
      last_strobe = cyc;
    end
    if (bus.rsp_valid && !rsp_prev) rsp_rise = cyc;
    rsp_prev = bus.rsp_valid;

    // Drive this cycle's inputs.
    rst     = rst_req;
    rst_req = 1'b0;
    c       = 16'($urandom);
    bus.cmd_valid = 1'b0;
    if (!rst) begin
      if (push_q.size() != 0) begin
        c = push_q[0];
        bus.cmd_valid = 1'b1;
      end else if ($urandom_range(0, 99) < push_pct) begin
        bus.cmd_valid = 1'b1;
      end
    end
    bus.cmd_rw    = c.rw;
    bus.cmd_addr  = c.addr;
    bus.cmd_data  = c.data;
    bus.speed_cfg = 2'($urandom);
    bus.rsp_ready = ($urandom_range(0, 99) < rdy_pct);
    bus.clr       = force_clr || ($urandom_range(0, 99) < clr_pct);
    force_clr     = 1'b0;
    in_wait = txn_open && (cyc > strobe_cyc) && (cyc < rsp_cyc);
    bus.m_done      = 1'b0;
    bus.m_data_rd   = 8'($urandom);
    bus.m_ack_error = 1'($urandom);
    if (in_wait) begin
      if (cyc == done_cyc) begin
        bus.m_done      = 1'b1;
        bus.m_data_rd   = drv_rd;
        bus.m_ack_error = drv_err;
      end
    end else if (force_done || $urandom_range(0, 15) == 0) begin
      bus.m_done = 1'b1;
    end
    force_done = 1'b0;

    // Advance the model by this cycle's events.
    if (rst) begin
      q.delete();
      txn_open = 1'b0;
      halt_m   = 1'b0;
      return;
    end
    pop_now = !txn_open && !halt_m && (q.size() != 0);
    if (halt_m) begin
      q.delete();
      if (bus.clr) halt_m = 1'b0;
    end
    if (rsp_now && bus.rsp_ready) begin
      txn_open = 1'b0;
      halt_m   = exp_to || exp_err;
    end
    if (pop_now) begin
      cur        = q.pop_front();
      cur_speed  = bus.speed_cfg;
      txn_open   = 1'b1;
      strobe_cyc = cyc + 1;
      plan_txn();
    end
    if (bus.cmd_valid && exp_ready) begin
      q.push_back(c);
      last_push = cyc;
      if (push_q.size() != 0) void'(push_q.pop_front());
    end
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while ((txn_open || q.size() != 0 || push_q.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) check("drain_budget", n, 0);
  endtask

  task automatic run_until_halt(input int max_cyc);
    int n = 0;
    while (!halt_m && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) check("halt_budget", n, 0);
  endtask

  initial begin
    int s0;
    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.speed_cfg = '0; bus.rsp_ready = 1'b0; bus.clr = 1'b0;
    bus.m_data_rd = '0; bus.m_done = 1'b0; bus.m_ack_error = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_cmd_level", bus.cmd_level, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_flags", {bus.rsp_ack_err, bus.rsp_timeout, bus.halted}, 0);
    check("rst_strobes", {bus.m_write, bus.m_read}, 0);
    check("rst_m_bus", {bus.m_addr, bus.m_data_wr, bus.m_speed_mode}, 0);

    // Single write, master answers 20 cycles after the strobe.
    fixed_delay = 20;
    push_q.push_back(cmd_t'{1'b0, 7'h50, 8'hA5});
    run_until_idle(100);
    check("wr_push_to_strobe", last_strobe - last_push, 2);
    check("wr_done_to_rsp", rsp_rise - last_strobe, 21);

    // Single read returning 0x3C.
    fixed_delay = 7;
    fixed_rd    = 8'h3C;
    push_q.push_back(cmd_t'{1'b1, 7'h51, 8'h00});
    run_until_idle(100);
    check("rd_done_to_rsp", rsp_rise - last_strobe, 8);
    fixed_rd = -1;

    // Fill with the response held off: FIFO saturates, one strobe outstanding.
    fixed_delay = 3;
    rdy_pct     = 0;
    s0          = n_strobe;
    for (int i = 0; i < DEPTH + 1; i++)
      push_q.push_back(cmd_t'{1'($urandom), 7'($urandom), 8'($urandom)});
    repeat (30) step();
    check("fill_level", bus.cmd_level, DEPTH);
    check("fill_ready", bus.cmd_ready, 0);
    check("fill_one_strobe", n_strobe - s0, 1);
    rdy_pct = 100;
    run_until_idle(400);
    check("fill_all_strobes", n_strobe - s0, DEPTH + 1);

    // ACK error on the first of three queued commands halts and flushes.
    fixed_delay = 5;
    force_err   = 1'b1;
    for (int i = 0; i < 3; i++)
      push_q.push_back(cmd_t'{1'b0, 7'(8'h10 + i), 8'($urandom)});
    run_until_halt(100);
    repeat (2) step();
    check("err_halted", bus.halted, 1);
    check("err_flushed", bus.cmd_level, 0);
    check("err_ready", bus.cmd_ready, 0);
    s0 = n_strobe;
    repeat (5) step();
    check("err_no_strobe", n_strobe - s0, 0);
    force_clr = 1'b1;
    repeat (2) step();
    check("clr_ready", bus.cmd_ready, 1);
    check("clr_halted", bus.halted, 0);

    // Timeout: master never completes.
    force_to = 1'b1;
    push_q.push_back(cmd_t'{1'b1, 7'h33, 8'h00});
    run_until_halt(100);
    check("to_latency", rsp_rise - last_strobe, TMO);
    step();
    check("to_halted", bus.halted, 1);
    force_clr = 1'b1;
    repeat (2) step();

    // Reset while waiting on the master; a late m_done must not create a response.
    fixed_delay = 10;
    push_q.push_back(cmd_t'{1'b0, 7'h22, 8'h5A});
    for (int i = 0; i < 40 && !(txn_open && cyc >= strobe_cyc + 3); i++) step();
    rst_req = 1'b1;
    repeat (2) step();
    check("rstw_rsp_valid", bus.rsp_valid, 0);
    check("rstw_m_bus", {bus.m_addr, bus.m_data_wr, bus.m_speed_mode}, 0);
    check("rstw_level_ready", {bus.cmd_level, bus.cmd_ready}, 1);
    force_done = 1'b1;
    repeat (6) step();
    check("rstw_no_rsp", bus.rsp_valid, 0);

    // Randomized traffic with backpressure, errors, timeouts and clr.
    fixed_delay = 0;
    push_pct    = 40;
    rdy_pct     = 60;
    clr_pct     = 20;
    repeat (3000) step();
    push_pct = 0;
    clr_pct  = 100;
    rdy_pct  = 100;
    run_until_idle(500);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
